// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Arbitrates a single-port framebuffer RAM between the VGA scanout
//   prefetcher (display bursts, priority) and a pixel writer. After every
//   display burst the writer is owed one slot (wr_turn), so a held wr_req
//   cannot be starved by back-to-back scanout bursts.
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   disp_req/disp_addr  burst request (held until disp_ack) and start address
//   disp_ack            one-cycle grant pulse, same cycle as the first read
//   disp_rdata          read data, taken straight from mem_rdata
//   disp_rvalid         disp_rdata valid this cycle
//   disp_done           coincides with the last disp_rvalid of a burst
//   wr_req/wr_addr/wr_data  write request (held until wr_ack)
//   wr_ack              one-cycle pulse, same cycle as the RAM write
//   mem_en/mem_we/mem_addr/mem_wdata  registered RAM command
//   mem_rdata           RAM read data, MEM_LAT cycles after the read
//   busy                arbiter is not idle
module vga_fb_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int BURST   = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              disp_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_N    = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_BURST, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;   // reads issued so far in this burst
  logic                last_q, last_d;       // read on the bus this cycle is the final one
  logic                wr_turn_q, wr_turn_d;
  logic                disp_ack_d, wr_ack_d, mem_en_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;

  // Read-return tracking: one stage per cycle of RAM latency.
  logic [MEM_LAT-1:0]  rd_vld_p;
  logic [MEM_LAT-1:0]  rd_last_p;

  assign disp_rdata  = mem_rdata;
  assign disp_rvalid = rd_vld_p[MEM_LAT-1];
  assign disp_done   = rd_vld_p[MEM_LAT-1] & rd_last_p[MEM_LAT-1];
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    last_d      = 1'b0;
    wr_turn_d   = wr_turn_q;
    disp_ack_d  = 1'b0;
    wr_ack_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state_q)
      ST_IDLE: begin
        // Display has priority unless the writer is owed its slot and is asking.
        if (disp_req && !(wr_turn_q && wr_req)) begin
          state_d    = ST_BURST;
          disp_ack_d = 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = disp_addr;
          rd_cnt_d   = CNT_W'(1);
          last_d     = (BURST_N == CNT_W'(1));
        end else if (wr_req) begin
          state_d     = ST_WRITE;
          wr_ack_d    = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr;
          mem_wdata_d = wr_data;
          wr_turn_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        // The write is on the bus this cycle; wr_req is not resampled here.
        state_d = ST_IDLE;
      end
      ST_BURST: begin
        if (rd_cnt_q != BURST_N) begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr + ADDR_W'(1);
          rd_cnt_d   = rd_cnt_q + CNT_W'(1);
          last_d     = (rd_cnt_q == BURST_LAST);
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (disp_done) begin
          state_d   = ST_IDLE;
          wr_turn_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      last_q    <= 1'b0;
      wr_turn_q <= 1'b0;
      disp_ack  <= 1'b0;
      wr_ack    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_vld_p  <= '0;
      rd_last_p <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      last_q    <= last_d;
      wr_turn_q <= wr_turn_d;
      disp_ack  <= disp_ack_d;
      wr_ack    <= wr_ack_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      // stage p0: read issued on the RAM bus this cycle
      rd_vld_p[0]  <= mem_en & ~mem_we;
      rd_last_p[0] <= last_q;
      // stages p1..: follow the RAM latency
      for (int i = 1; i < MEM_LAT; i++) begin
        rd_vld_p[i]  <= rd_vld_p[i-1];
        rd_last_p[i] <= rd_last_p[i-1];
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int BURST   = 16;
  localparam int MEM_LAT = 2;
  localparam int AMASK   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_ack;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              disp_done;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid), .disp_done(disp_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM: preloaded with data = addr[7:0], MEM_LAT read latency.
  logic [DATA_W-1:0] ram [0:AMASK];
  logic              ram_ready = 1'b0;
  logic [DATA_W-1:0] rd_pipe [MEM_LAT];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i <= AMASK; i++) ram[i] <= DATA_W'(i);
      ram_ready <= 1'b1;
    end else begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      rd_pipe[0] <= ram[mem_addr];
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Reference picture of the framebuffer contents.
  logic [DATA_W-1:0] ref_mem [int];
  function automatic logic [DATA_W-1:0] ref_rd(int a);
    if (ref_mem.exists(a & AMASK)) return ref_mem[a & AMASK];
    return DATA_W'(a);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    disp_req = 1'b0;
    wr_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({disp_ack, disp_rvalid, disp_done, wr_ack, mem_en, mem_we, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {disp_ack, disp_rvalid, disp_done, wr_ack, mem_en, mem_we, busy});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr %h data %h want 0", mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({busy, mem_en, disp_ack, wr_ack} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b want 0000", {busy, mem_en, disp_ack, wr_ack});
    end
  endtask

  // Issue one burst from IDLE and check it cycle by cycle from the timing rules.
  task automatic run_burst(input string nm, input int a);
    logic e_ack, e_en, e_rv, e_done, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    disp_addr = ADDR_W'(a);
    disp_req = 1'b1;
    for (int k = 1; k <= BURST + MEM_LAT + 1; k++) begin
      step();
      e_ack  = (k == 1);
      e_en   = (k <= BURST);
      e_rv   = (k >= 1 + MEM_LAT) && (k <= BURST + MEM_LAT);
      e_done = (k == BURST + MEM_LAT);
      e_busy = (k <= BURST + MEM_LAT);
      checks++;
      if (disp_ack !== e_ack) begin
        errors++; $display("FAIL %s ack k=%0d: got %b want %b", nm, k, disp_ack, e_ack);
      end
      checks++;
      if (mem_en !== e_en || mem_we !== 1'b0) begin
        errors++; $display("FAIL %s mem_en/we k=%0d: got %b%b want %b0", nm, k, mem_en, mem_we, e_en);
      end
      if (e_en) begin
        e_addr = ADDR_W'(a + k - 1);
        checks++;
        if (mem_addr !== e_addr) begin
          errors++; $display("FAIL %s addr k=%0d: got %h want %h", nm, k, mem_addr, e_addr);
        end
      end
      checks++;
      if (disp_rvalid !== e_rv) begin
        errors++; $display("FAIL %s rvalid k=%0d: got %b want %b", nm, k, disp_rvalid, e_rv);
      end
      if (e_rv) begin
        e_data = ref_rd(a + k - 1 - MEM_LAT);
        checks++;
        if (disp_rdata !== e_data) begin
          errors++; $display("FAIL %s rdata k=%0d: got %h want %h", nm, k, disp_rdata, e_data);
        end
      end
      checks++;
      if (disp_done !== e_done) begin
        errors++; $display("FAIL %s done k=%0d: got %b want %b", nm, k, disp_done, e_done);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++; $display("FAIL %s busy k=%0d: got %b want %b", nm, k, busy, e_busy);
      end
      if (k == 1) disp_req = 1'b0;
    end
  endtask

  task automatic test_burst();
    run_burst("burst100", 32'h00100);
  endtask

  task automatic test_write_wrap();
    wr_addr = ADDR_W'(AMASK);
    wr_data = 8'hA5;
    wr_req = 1'b1;
    step();
    checks++;
    if ({wr_ack, mem_en, mem_we, busy} !== 4'b1111 || mem_addr !== ADDR_W'(AMASK) || mem_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL write_cycle: got ack/en/we/busy %b addr %h data %h want 1111 1ffff a5",
               {wr_ack, mem_en, mem_we, busy}, mem_addr, mem_wdata);
    end
    ref_mem[AMASK] = 8'hA5;
    wr_req = 1'b0;
    step();
    checks++;
    if ({wr_ack, mem_we, busy} !== 3'b000) begin
      errors++; $display("FAIL write_end: got ack/we/busy %b want 000", {wr_ack, mem_we, busy});
    end
    run_burst("wrap", AMASK);
  endtask

  task automatic test_simultaneous();
    int d1, d2, w;
    do_reset();
    d1 = -1; d2 = -1; w = -1;
    disp_addr = ADDR_W'($urandom);
    wr_addr = ADDR_W'($urandom);
    wr_data = DATA_W'($urandom);
    disp_req = 1'b1;
    wr_req = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (disp_ack === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (wr_ack === 1'b1 && w < 0) begin
        w = k;
        ref_mem[int'(wr_addr)] = wr_data;
        wr_req = 1'b0;
      end
      if (d2 >= 0) disp_req = 1'b0;
    end
    disp_req = 1'b0;
    wr_req = 1'b0;
    checks++;
    if (d1 != 1) begin errors++; $display("FAIL simul_first_ack: got cycle %0d want 1", d1); end
    checks++;
    if (w != BURST + MEM_LAT + 2) begin
      errors++; $display("FAIL simul_wr_ack: got cycle %0d want %0d", w, BURST + MEM_LAT + 2);
    end
    checks++;
    if (d2 != BURST + MEM_LAT + 4) begin
      errors++; $display("FAIL simul_second_ack: got cycle %0d want %0d", d2, BURST + MEM_LAT + 4);
    end
  endtask

  task automatic test_wr_stream();
    int nack;
    logic e_ack;
    logic [ADDR_W-1:0] base;
    do_reset();
    nack = 0;
    base = ADDR_W'($urandom);
    wr_addr = base;
    wr_data = DATA_W'($urandom);
    wr_req = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      e_ack = (k % 2 == 1) && (k <= 20);
      if (wr_ack === 1'b1) nack++;
      checks++;
      if (wr_ack !== e_ack || mem_we !== e_ack || busy !== e_ack) begin
        errors++;
        $display("FAIL stream k=%0d: got ack/we/busy %b%b%b want %b%b%b", k, wr_ack, mem_we, busy, e_ack, e_ack, e_ack);
      end
      if (e_ack) begin
        checks++;
        if (mem_addr !== wr_addr || mem_wdata !== wr_data) begin
          errors++;
          $display("FAIL stream_data k=%0d: got %h/%h want %h/%h", k, mem_addr, mem_wdata, wr_addr, wr_data);
        end
        ref_mem[int'(wr_addr)] = wr_data;
        wr_addr = wr_addr + ADDR_W'(1);
        wr_data = DATA_W'($urandom);
      end
      if (k == 20) wr_req = 1'b0;
    end
    checks++;
    if (nack != 10) begin errors++; $display("FAIL stream_count: got %0d acks want 10", nack); end
  endtask

  task automatic test_reset_mid_burst();
    int a;
    a = int'($urandom) & AMASK;
    disp_addr = ADDR_W'(a);
    disp_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) disp_req = 1'b0;
    end
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== ADDR_W'(a + 4)) begin
      errors++; $display("FAIL midrst_5th_read: got en %b addr %h want 1 %h", mem_en, mem_addr, ADDR_W'(a + 4));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({disp_ack, disp_rvalid, disp_done, wr_ack, mem_en, mem_we, busy} !== 7'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL midrst_async: got %b addr %h data %h want all 0",
               {disp_ack, disp_rvalid, disp_done, wr_ack, mem_en, mem_we, busy}, mem_addr, mem_wdata);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      checks++;
      if ({disp_rvalid, disp_done, busy, mem_en} !== 4'b0) begin
        errors++;
        $display("FAIL midrst_quiet k=%0d: got rv/done/busy/en %b want 0000", k, {disp_rvalid, disp_done, busy, mem_en});
      end
    end
    run_burst("after_rst", int'($urandom) & AMASK);
  endtask

  // Random traffic against a transaction-level model: each grant books its
  // ack, read window, data return and idle time by arithmetic on the grant cycle.
  task automatic test_random();
    int dack_c, wack_c, bstart, baddr, idle_at, grant_c;
    bit turn;
    logic e_rv, e_done, e_busy, e_en;
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;
    do_reset();
    dack_c = -100; wack_c = -100; bstart = -100; baddr = 0; idle_at = 0; grant_c = -100;
    turn = 1'b0; w_a = '0; w_d = '0;
    for (int c = 0; c < 900; c++) begin
      e_rv   = (c >= bstart + MEM_LAT) && (c <= bstart + BURST - 1 + MEM_LAT);
      e_done = (c == bstart + BURST - 1 + MEM_LAT);
      e_busy = (c > grant_c) && (c < idle_at);
      e_en   = ((c >= bstart) && (c <= bstart + BURST - 1)) || (c == wack_c);
      checks++;
      if (disp_ack !== (c == dack_c) || wr_ack !== (c == wack_c)) begin
        errors++;
        $display("FAIL rnd_ack c=%0d: got disp %b wr %b want %b %b", c, disp_ack, wr_ack, c == dack_c, c == wack_c);
      end
      checks++;
      if (disp_rvalid !== e_rv || disp_done !== e_done || busy !== e_busy || mem_en !== e_en) begin
        errors++;
        $display("FAIL rnd_ctrl c=%0d: got rv/done/busy/en %b%b%b%b want %b%b%b%b", c,
                 disp_rvalid, disp_done, busy, mem_en, e_rv, e_done, e_busy, e_en);
      end
      if (e_rv) begin
        checks++;
        if (disp_rdata !== ref_rd(baddr + c - bstart - MEM_LAT)) begin
          errors++;
          $display("FAIL rnd_rdata c=%0d: got %h want %h", c, disp_rdata, ref_rd(baddr + c - bstart - MEM_LAT));
        end
      end
      if (c == wack_c) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== w_a || mem_wdata !== w_d) begin
          errors++;
          $display("FAIL rnd_write c=%0d: got we %b %h/%h want 1 %h/%h", c, mem_we, mem_addr, mem_wdata, w_a, w_d);
        end
      end
      // requesters: drop on the expected grant, raise new requests at random
      if (c == dack_c) disp_req = 1'b0;
      if (c == wack_c) wr_req = 1'b0;
      if (!disp_req && $urandom_range(0, 5) == 0) begin
        disp_req = 1'b1;
        if ($urandom_range(0, 3) == 0) disp_addr = ADDR_W'(AMASK - int'($urandom_range(0, 20)));
        else disp_addr = ADDR_W'($urandom);
      end
      if (!wr_req && $urandom_range(0, 3) == 0) begin
        wr_req = 1'b1;
        wr_addr = ADDR_W'($urandom);
        wr_data = DATA_W'($urandom);
      end
      // arbitration decision for this cycle's requests
      if (c >= idle_at) begin
        if (disp_req && !(turn && wr_req)) begin
          grant_c = c; dack_c = c + 1; bstart = c + 1; baddr = int'(disp_addr);
          idle_at = c + BURST + MEM_LAT + 1;
          turn = 1'b1;
        end else if (wr_req) begin
          grant_c = c; wack_c = c + 1; w_a = wr_addr; w_d = wr_data;
          ref_mem[int'(wr_addr)] = wr_data;
          idle_at = c + 2;
          turn = 1'b0;
        end
      end
      step();
    end
    disp_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_burst();
    test_write_wrap();
    test_simultaneous();
    test_wr_stream();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer RAM arbiter between the VGA scanout prefetcher (display) and a pixel writer (pattern generator or CPU). Display bursts have priority, so scanout never waits behind writes. Fairness guarantees the writer one slot between consecutive bursts. Sits between the line prefetch logic driven by the sync generator's blanking window and the framebuffer RAM.

## Interface
- ADDR_W, 17, framebuffer word address width
- DATA_W, 8, pixel word width
- BURST, 16, reads per display burst (≥1)
- MEM_LAT, 2, RAM read latency in cycles (≥1)

- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display burst request, held until disp_ack
- disp_addr  in  ADDR_W  burst start address, captured with disp_ack
- disp_ack  out  1  one-cycle grant pulse
- disp_rdata  out  DATA_W  read data, driven directly from mem_rdata
- disp_rvalid  out  1  disp_rdata valid this cycle
- disp_done  out  1  pulse coincident with the last disp_rvalid of a burst
- wr_req  in  1  write request, held until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse, coincident with the RAM write
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, MEM_LAT cycles after the read
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WRITE, BURST, DRAIN.
- In IDLE, requests are sampled and a winner is picked:
  - disp_req wins over wr_req, unless the wr_turn flag is set and wr_req is high.
  - Display winner: go to BURST, register disp_ack, capture disp_addr, reset the read counter.
  - Writer winner: go to WRITE, register wr_ack, mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. Clear wr_turn.
  - No request: mem_en=0, mem_we=0.
- WRITE: lasts exactly one cycle (the write cycle), then returns to IDLE. The still-high wr_req is not reissued in that cycle.
- BURST: one read per cycle, mem_en=1, mem_we=0, mem_addr = start + n for n = 0..BURST-1. The address wraps modulo 2^ADDR_W. After read BURST-1, go to DRAIN.
- DRAIN: mem_en=0. Wait until the last read's data returns, then go to IDLE and set wr_turn.
- Read tracking: a MEM_LAT-deep valid shift register is loaded with 1 per issued read. Its output is disp_rvalid. disp_done = disp_rvalid AND last-read tag.
- wr_turn is cleared when a write is served. If wr_req is low at burst end, wr_turn is held but does not block a display request (display wins when wr_req is low).
- wr_req is ignored while busy. disp_req is ignored while busy.

## Timing
- Reset values: disp_ack, disp_rvalid, disp_done, wr_ack, mem_en, mem_we, busy = 0. mem_addr, mem_wdata = 0. State IDLE, wr_turn = 0, valid pipeline cleared.
- Reset mid-burst or mid-drain: no further disp_rvalid or disp_done after release. The requester re-requests.
- Display request sampled high in IDLE at cycle t:
  - disp_ack and the first read (addr A) occur in cycle t+1.
  - Reads occur in cycles t+1 .. t+BURST.
  - disp_rvalid is high in cycles t+1+MEM_LAT .. t+BURST+MEM_LAT.
  - disp_done occurs in cycle t+BURST+MEM_LAT.
  - IDLE is reached in cycle t+BURST+MEM_LAT+1.
- Write request sampled in IDLE at cycle t: wr_ack and mem_we in cycle t+1, IDLE at t+2. Sustained write throughput is 1 per 2 cycles.
- Simultaneous disp_req and wr_req with wr_turn=0: display wins.
- Simultaneous disp_req and wr_req with wr_turn=1: writer wins, then display is granted 2 cycles later.
- Worst-case writer wait: BURST+MEM_LAT+3 cycles.

## Test plan
- Reset, then disp_req with disp_addr=0x00100 (BURST=16, MEM_LAT=2, RAM preloaded data=addr[7:0]) -> disp_ack 1 cycle later, reads at 0x00100..0x0010F, disp_rdata sequence 0x00..0x0F, disp_done on the 16th rvalid, busy low 19 cycles after request.
- wr_req at 0x1FFFF, data 0xA5, no display traffic -> wr_ack/mem_we single-cycle pulse with mem_addr=0x1FFFF, mem_wdata=0xA5; readback burst from 0x1FFFF returns 0xA5 then wraps to 0x00000.
- disp_req and wr_req asserted together from IDLE -> burst granted first; wr_ack occurs before the second disp_ack although disp_req stays high.
- wr_req held high continuously -> exactly one wr_ack per 2 cycles, no duplicate writes.
- Assert rst_n low during the 5th read of a burst -> all outputs 0 asynchronously; no disp_rvalid or disp_done after release; a new request completes normally.
